// File: rtl/alu_pkg.sv
// Shared definitions for the Z-stage ALU: opcodes, flag bit positions, FSM encoding.
// No logic; constants, types and a flag-packing helper only.
// Imported by alu_z and alu_mul_seq.
package alu_pkg;

  // Opcodes sampled with Z_in. Codes 11-15 are reserved and fall back to PASS_A.
  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_PASS_B = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_NOT_A  = 4'd7;
  localparam logic [3:0] OP_INC_A  = 4'd8;
  localparam logic [3:0] OP_DEC_A  = 4'd9;
  localparam logic [3:0] OP_MUL    = 4'd10;

  // Bit positions inside the 4-bit flags vector {N, Zf, C, V}.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Top-level sequencing: idle (single-cycle ops complete here) or multiplying.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Pack individual condition bits into the flags vector at their fixed positions.
  function automatic logic [3:0] make_flags(input logic n, input logic zf,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = zf;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned WxW shift-add multiplier, one multiplier bit retired per clock.
// Latency: CYCLES clocks after start; product is presented combinationally on the last step.
// No backpressure: start is only honoured when the owner is idle; busy gates each step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W      = 16,
  parameter int CYCLES = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           busy,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last,
  output logic [2*W-1:0] product
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] addend;

  // Partial product for this step: the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    addend = '0;
    if (mplier[0]) begin
      addend = mcand;
    end
  end

  // Accumulator value after the current step; on the final step this is the full product.
  always_comb begin
    product = acc + addend;
  end

  assign last = busy && (cnt == CW'(CYCLES - 1));

  // Operand capture on start, then one shift-add step per clock while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_z.sv
// Z-stage ALU: combinational op on (shifter, W-bus) latched into Z/flags; MUL via shift-add sequencer.
// Latency: 1 clock for single-cycle ops, MUL_CYCLES clocks for MUL; done pulses the cycle after the write.
// Backpressure: Z_in is dropped silently while busy; a new Z_in is accepted on the cycle done is high.
module alu_z
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] from_shifter,
  input  logic [WIDTH-1:0] DATA,
  input  logic [3:0]       alu_op,
  input  logic             Z_in,
  input  logic             Z_out,
  output logic [WIDTH-1:0] REG_OUT_Z,
  output logic [WIDTH-1:0] REG_OUT_ZH,
  output logic [WIDTH-1:0] BUS_OUT_Z,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  state_t             state;
  state_t             next_state;
  logic               wr_alu;
  logic               mul_start;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     alu_ext;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flags;
  logic [3:0]         mul_flags;

  assign busy      = (state == S_MUL);
  assign BUS_OUT_Z = Z_out ? REG_OUT_Z : '0;

  alu_mul_seq #(
    .W      (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .busy    (busy),
    .a       (from_shifter),
    .b       (DATA),
    .last    (mul_last),
    .product (mul_product)
  );

  // Single-cycle datapath: 17-bit arithmetic so the carry/borrow falls out of the top bit.
  always_comb begin
    alu_res = from_shifter;
    alu_ext = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_PASS_A: alu_res = from_shifter;
      OP_PASS_B: alu_res = DATA;
      OP_ADD: begin
        alu_ext = {1'b0, from_shifter} + {1'b0, DATA};
        alu_res = alu_ext[MSB:0];
        alu_c   = alu_ext[WIDTH];
        alu_v   = (from_shifter[MSB] == DATA[MSB]) && (alu_res[MSB] != from_shifter[MSB]);
      end
      OP_SUB: begin
        alu_ext = {1'b0, from_shifter} - {1'b0, DATA};
        alu_res = alu_ext[MSB:0];
        alu_c   = ~alu_ext[WIDTH];
        alu_v   = (from_shifter[MSB] != DATA[MSB]) && (alu_res[MSB] != from_shifter[MSB]);
      end
      OP_AND:   alu_res = from_shifter & DATA;
      OP_OR:    alu_res = from_shifter | DATA;
      OP_XOR:   alu_res = from_shifter ^ DATA;
      OP_NOT_A: alu_res = ~from_shifter;
      OP_INC_A: begin
        alu_ext = {1'b0, from_shifter} + (WIDTH + 1)'(1);
        alu_res = alu_ext[MSB:0];
        alu_c   = alu_ext[WIDTH];
        alu_v   = ~from_shifter[MSB] && alu_res[MSB];
      end
      OP_DEC_A: begin
        alu_ext = {1'b0, from_shifter} - (WIDTH + 1)'(1);
        alu_res = alu_ext[MSB:0];
        alu_c   = ~alu_ext[WIDTH];
        alu_v   = from_shifter[MSB] && ~alu_res[MSB];
      end
      default:  alu_res = from_shifter;
    endcase
  end

  // Flag vectors for both write sources; MUL reports a nonzero high word as carry.
  always_comb begin
    alu_flags = make_flags(alu_res[MSB], (alu_res == '0), alu_c, alu_v);
    mul_flags = make_flags(mul_product[MSB], (mul_product[MSB:0] == '0),
                           (mul_product[2*WIDTH-1:WIDTH] != '0), 1'b0);
  end

  // Next-state and strobe decode: Z_in only matters in IDLE, which is how starts during MUL are dropped.
  always_comb begin
    next_state = state;
    wr_alu     = 1'b0;
    mul_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Z_in) begin
          if (alu_op == OP_MUL) begin
            mul_start  = 1'b1;
            next_state = S_MUL;
          end else begin
            wr_alu = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_last) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Result registers: ZH only moves on a multiply, done marks the cycle after any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      REG_OUT_Z  <= '0;
      REG_OUT_ZH <= '0;
      flags      <= 4'b0000;
      done       <= 1'b0;
    end else begin
      done <= wr_alu | mul_last;
      if (wr_alu) begin
        REG_OUT_Z <= alu_res;
        flags     <= alu_flags;
      end else if (mul_last) begin
        REG_OUT_Z  <= mul_product[MSB:0];
        REG_OUT_ZH <= mul_product[2*WIDTH-1:WIDTH];
        flags      <= mul_flags;
      end
    end
  end

endmodule

// File: doc/alu_z.md
# alu_z

Datapath stage directly downstream of the Y register/shifter pair. Takes the shifted Y operand (A) and the current W-bus value (B), computes an ALU result and latches it, with condition flags, into the Z register. Single-cycle ops finish in one clock; unsigned 16x16 multiply runs as a 16-cycle shift-add sequence behind a busy/done handshake. Z is read back onto the W bus by the top level when `Z_out` is asserted.

## Interface
- `WIDTH`, 16: operand and Z register width.
- `MUL_CYCLES`, 16: multiply iterations. Must equal `WIDTH`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `from_shifter`  in  16  operand A, from the shifter output `Y_shifted`.
- `DATA`  in  16  operand B, from the W bus.
- `alu_op`  in  4  opcode, sampled with `Z_in`.
- `Z_in`  in  1  start strobe: latch operands and opcode, begin the operation.
- `Z_out`  in  1  read enable for the bus driver.
- `REG_OUT_Z`  out  16  Z register (low word).
- `REG_OUT_ZH`  out  16  high word of the last multiply; otherwise unchanged.
- `BUS_OUT_Z`  out  16  equals Z when `Z_out`=1, else 16'h0000.
- `flags`  out  4  {N, Zf, C, V}.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse when a result has been written.

## Operation
- Opcodes: 0 PASS_A, 1 PASS_B, 2 ADD, 3 SUB (A-B), 4 AND, 5 OR, 6 XOR, 7 NOT_A, 8 INC_A, 9 DEC_A, 10 MUL. Codes 11-15 are reserved and behave as PASS_A.
- Reset: Z=0, ZH=0, flags=0, busy=0, done=0, FSM=IDLE.
- FSM states:
  - IDLE: on `Z_in` with a single-cycle op, write Z and flags and stay in IDLE. On `Z_in` with MUL, latch A and B, clear the accumulator, go to MUL.
  - MUL: shift-add one bit per cycle; counter runs 0..15. When counter=15, write {ZH,Z}=product and go to IDLE.
- Arithmetic is on 17 bits.
  - C = carry out for ADD and INC. For SUB and DEC, C = no-borrow (A>=B).
  - V = signed overflow for ADD, SUB, INC, DEC; 0 otherwise.
  - N = result[15]. Zf = (result==0).
  - Logic and PASS ops clear C and V.
  - MUL: C=(ZH!=0), V=0; N and Zf are computed from the low word.
- `Z_in` while busy is ignored; no error is raised.
- Operands are captured at the start edge, so DATA and from_shifter may change during MUL.
- `reset` during MUL aborts immediately. Z and ZH go to 0; no `done` pulse is issued.
- `Z_in` and `reset` in the same cycle: reset wins.
- No wrap-around protection: ADD/INC/DEC results wrap modulo 2^16.

## Timing
- Single-cycle op: `Z_in` high at edge k → Z and flags valid after edge k; `done`=1 during cycle k+1.
- MUL: `Z_in` at edge k → `busy`=1 from edge k through edge k+16. Result is valid after edge k+16, when `busy` falls. `done`=1 during the following cycle.
- Back-to-back: a new `Z_in` is accepted on the edge where `done` is high.
- `BUS_OUT_Z` is combinational from Z and `Z_out`, with zero latency.

## Structure
- Package `alu_pkg` holds the opcode localparams (`OP_PASS_A` … `OP_MUL`), the flag bit indices, and the FSM state encoding.
- Sub-module `alu_mul_seq` contains the multiplicand/multiplier shift registers, the 32-bit accumulator and the 4-bit counter, with ports start/busy/last/product. `alu_z` holds the combinational ALU, the Z/ZH/flag registers and the top-level FSM.

## Test plan
- ADD: A=0x0003, B=0xFFFF, `Z_in` → Z=0x0002, C=1, V=0, N=0, Zf=0; `done` one cycle later.
- ADD overflow: A=0x7FFF, B=0x0001 → Z=0x8000, N=1, V=1, C=0.
- SUB equal: A=0x0005, B=0x0005 → Z=0x0000, Zf=1, C=1.
- MUL with operand changes: A=0x0100, B=0x0100, pulse `Z_in`, then drive B=0xFFFF → `busy` for 16 cycles; ZH=0x0001, Z=0x0000, C=1.
- Ignored start: issue XOR (A=0xABAA, B=0xFFFF) mid-MUL → ignored; MUL result unchanged. Issue the same XOR after `done` → Z=0x5455.
- Reset abort: assert `reset` at MUL cycle 8 → next cycle busy=0, Z=0, ZH=0, flags=0, no `done`; `BUS_OUT_Z`=0 whether `Z_out` is 0 or 1.
